// File: rtl/writeback_queue_if.sv
// ---------------------------------------------------------------------------
// writeback_queue_if
//   Bundles the writeback queue's upstream result handshake, register-file
//   write stage, forwarding lookup and occupancy status.
//
//   master : the producer side (execute stage / decode-stage checker).
//   slave  : the writeback queue itself.
//
//   res_valid/res_ready/res_addr/res_data : result handshake into the queue
//   hold                                  : downstream write port busy
//   wr_en/wr_addr/wr_data                 : registered register-file write
//   chk_addrA/B, fwd_hitA/B, fwd_dataA/B  : forwarding lookup
//   occupancy                             : number of queued entries
// ---------------------------------------------------------------------------
interface writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] chk_addrA;
  logic [ADDR_W-1:0] chk_addrB;
  logic              fwd_hitA;
  logic              fwd_hitB;
  logic [DATA_W-1:0] fwd_dataA;
  logic [DATA_W-1:0] fwd_dataB;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output res_valid, res_addr, res_data, hold, chk_addrA, chk_addrB,
    input  res_ready, wr_en, wr_addr, wr_data,
    input  fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, occupancy
  );

  modport slave (
    input  res_valid, res_addr, res_data, hold, chk_addrA, chk_addrB,
    output res_ready, wr_en, wr_addr, wr_data,
    output fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, occupancy
  );
endinterface

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//   Strict-FIFO queue of pending register-file writes. Results are pushed at
//   the tail on a valid/ready handshake; each cycle without hold the head is
//   moved into a registered write stage (wr_en/wr_addr/wr_data) that stays
//   stable for the whole cycle so the register file can write on negedge.
//   Two combinational lookup ports report whether a pending write targets a
//   given register and return the newest such value for bypassing.
//
//   clk   : single clock, posedge
//   rst_n : asynchronous active-low reset
//   bus   : writeback_queue_if.slave (handshake, write stage, lookup, status)
// ---------------------------------------------------------------------------
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              push;
  logic              pop;

  // Ready depends only on the registered count, so a same-cycle pop never
  // opens a slot for a push on a full queue.
  always_comb begin
    push      = bus.res_valid && (count_q != CNT_FULL);
    pop       = (count_q != '0) && !bus.hold;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en_d   = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (push) tail_d = tail_q + PTR_ONE;
    if (pop) begin
      head_d    = head_q + PTR_ONE;
      wr_addr_d = mem_q[head_q].addr;
      wr_data_d = mem_q[head_q].data;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; an entry is only ever
  // read while the count marks it valid, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {bus.res_addr, bus.res_data};
  end

  // Forwarding lookup. The write stage is the oldest pending value, then the
  // queue from head (oldest) to tail (youngest); later matches override
  // earlier ones so the youngest pending write wins.
  logic [ADDR_W-1:0] chk_addr [2];
  logic              fwd_hit  [2];
  logic [DATA_W-1:0] fwd_data [2];

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path can leave it unassigned and infer a latch.
  always_comb begin
    chk_addr[0] = bus.chk_addrA;
    chk_addr[1] = bus.chk_addrB;
    for (int p = 0; p < 2; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      if (wr_en_q && (wr_addr_q == chk_addr[p])) begin
        fwd_hit[p]  = 1'b1;
        fwd_data[p] = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count_q) &&
            (mem_q[head_q + PTR_W'(i)].addr == chk_addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = mem_q[head_q + PTR_W'(i)].data;
        end
      end
    end
  end

  assign bus.res_ready = (count_q != CNT_FULL);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.occupancy = count_q;
  assign bus.fwd_hitA  = fwd_hit[0];
  assign bus.fwd_hitB  = fwd_hit[1];
  assign bus.fwd_dataA = fwd_data[0];
  assign bus.fwd_dataB = fwd_data[1];

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, result-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter: ADDR_W, 5, register address width.
REQ-003 SHALL have parameter: DATA_W, 16, register data width.
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: res_valid  input  1  upstream result valid.
REQ-007 SHALL have port: res_ready  output  1  queue can accept a result.
REQ-008 SHALL have port: res_addr  input  ADDR_W  destination register of result.
REQ-009 SHALL have port: res_data  input  DATA_W  result value.
REQ-010 SHALL have port: hold  input  1  downstream write port unavailable; suppresses pop.
REQ-011 SHALL have port: wr_en  output  1  register-file write enable (drives enable_C).
REQ-012 SHALL have port: wr_addr  output  ADDR_W  register-file write address (drives write_addC).
REQ-013 SHALL have port: wr_data  output  DATA_W  register-file write data (drives write_dataC).
REQ-014 SHALL have ports: chk_addrA, chk_addrB  input  ADDR_W  decode-stage source addresses to check.
REQ-015 SHALL have ports: fwd_hitA, fwd_hitB  output  1  pending write to checked address exists.
REQ-016 SHALL have ports: fwd_dataA, fwd_dataB  output  DATA_W  newest pending value for checked address.
REQ-017 SHALL have port: occupancy  output  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-018 SHALL accept a result on a posedge where res_valid=1 and res_ready=1, writing {res_addr,res_data} at the tail.
REQ-019 SHALL drive res_ready=1 iff occupancy<DEPTH (combinational from count; not relaxed by a same-cycle pop).
REQ-020 SHALL, on each posedge with occupancy>0 and hold=0, pop the head into registered wr_addr/wr_data and set wr_en=1.
REQ-021 SHALL set wr_en=0 on any posedge with occupancy=0 or hold=1; wr_addr/wr_data then hold their last values.
REQ-022 SHALL keep wr_* registered and stable for the full cycle so the register file's negedge write samples them mid-cycle.
REQ-023 SHALL give latency: result accepted at posedge N into an empty queue with hold=0 appears on wr_* after posedge N+1 and is written at the following negedge.
REQ-024 SHALL support simultaneous push and pop; occupancy unchanged, order preserved (strict FIFO).
REQ-025 SHALL wrap head/tail pointers modulo DEPTH with no loss or duplication.
REQ-026 SHALL ignore res_valid when res_ready=0; res_addr/res_data are not sampled.
REQ-027 SHALL compute fwd_hitX combinationally: 1 if any queued entry or the current wr_* stage (wr_en=1) matches chk_addrX.
REQ-028 SHALL select fwd_dataX from the newest match: youngest queued entry first, then older entries, then wr_* stage.
REQ-029 SHALL drive fwd_hitX=0 and fwd_dataX=0 when no match.
REQ-030 SHALL treat address 0 as an ordinary register (no special-casing).
REQ-031 SHALL not reorder or coalesce multiple queued writes to the same address; each is written in order.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously clear: occupancy=0, pointers=0, wr_en=0, wr_addr=0, wr_data=0; res_ready=1; fwd_hitA/B=0.
REQ-033 SHALL discard all queued entries on reset mid-operation; no wr_en pulse after reset release until a new result is accepted.
REQ-034 SHALL resume normal operation on the first posedge after rst_n rises.

Verification
REQ-035 SHALL cover: single push addr=3 data=0x1234, hold=0 -> one cycle later wr_en=1, wr_addr=3, wr_data=0x1234 for exactly one cycle.
REQ-036 SHALL cover: hold=1, push 5 results back-to-back (DEPTH=4) -> res_ready=0 after 4th, 5th not accepted, occupancy=4; release hold -> 4 writes in push order on consecutive cycles.
REQ-037 SHALL cover: hold=1, push addr=7 data=0x0001 then addr=7 data=0x0002; chk_addrA=7 -> fwd_hitA=1, fwd_dataA=0x0002; chk_addrB=8 -> fwd_hitB=0, fwd_dataB=0.
REQ-038 SHALL cover: full queue, hold=0, res_valid=1 continuous -> res_ready=0 for that cycle, occupancy drops to 3, next push accepted, pointer wrap passes 10+ entries in order.
REQ-039 SHALL cover: rst_n asserted with occupancy=3 between clock edges -> wr_en=0, occupancy=0 immediately; after release no writes emitted.
REQ-040 SHALL cover: random push/hold traffic vs. scoreboard model of register file -> final register contents and every wr_* sequence match.
